// File: rtl/regfile_pkg.sv
// Shared types and sizes for the register-file writeback path.
// Used by wb_fifo and regfile_wb_ctrl.
package regfile_pkg;

  localparam int XLEN       = 19;
  localparam int NREG       = 8;
  localparam int AW         = $clog2(NREG);
  localparam int FIFO_DEPTH = 4;
  localparam int PTR_W      = $clog2(FIFO_DEPTH);
  localparam int CNT_W      = PTR_W + 1;

  typedef logic [AW-1:0]   reg_addr_t;
  typedef logic [XLEN-1:0] reg_data_t;

  typedef struct packed {
    reg_addr_t rd;
    reg_data_t data;
  } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Two-push / one-pop in-order writeback queue.
// Entries are also exported oldest-first for busy and bypass lookups.
module wb_fifo
  import regfile_pkg::*;
(
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic                             push0,
  input  wb_entry_t                        din0,
  input  logic                             push1,
  input  wb_entry_t                        din1,
  input  logic                             pop,
  output wb_entry_t                        head,
  output logic [CNT_W-1:0]                 count,
  output logic [FIFO_DEPTH-1:0]            ord_valid,
  output wb_entry_t [FIFO_DEPTH-1:0]       ord_ent
);

  wb_entry_t [FIFO_DEPTH-1:0] mem;
  logic [PTR_W-1:0]           rptr;
  logic [PTR_W-1:0]           wptr;

  // push0 always lands ahead of push1 when both fire
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem   <= '0;
      rptr  <= '0;
      wptr  <= '0;
      count <= '0;
    end else begin
      if (push0)
        mem[wptr] <= din0;
      if (push1)
        mem[wptr + PTR_W'(push0)] <= din1;
      wptr  <= wptr + PTR_W'(push0)
                    + PTR_W'(push1);
      if (pop)
        rptr <= rptr + PTR_W'(1);
      count <= count + CNT_W'(push0)
                     + CNT_W'(push1)
                     - CNT_W'(pop);
    end
  end

  assign head = mem[rptr];

  always_comb begin
    ord_valid = '0;
    ord_ent   = '0;
    for (int k = 0; k < FIFO_DEPTH; k++) begin
      ord_ent[k]   = mem[rptr + PTR_W'(k)];
      ord_valid[k] = CNT_W'(k) < count;
    end
  end

endmodule

// File: rtl/regfile_wb_ctrl.sv
// Writeback controller: queues ALU/load results, retires one write per cycle.
// Define WB_BYPASS_EN to add combinational read forwarding ports.
module regfile_wb_ctrl
  import regfile_pkg::*;
(
  input  logic            clk,
  input  logic            reset_n,
  input  logic            mem_valid_i,
  output logic            mem_ready_o,
  input  reg_addr_t       mem_rd_i,
  input  reg_data_t       mem_data_i,
  input  logic            alu_valid_i,
  output logic            alu_ready_o,
  input  reg_addr_t       alu_rd_i,
  input  reg_data_t       alu_data_i,
`ifdef WB_BYPASS_EN
  input  reg_addr_t       rs1_addr_i,
  input  reg_addr_t       rs2_addr_i,
  input  reg_data_t       rs1_data_i,
  input  reg_data_t       rs2_data_i,
  output reg_data_t       rs1_fwd_o,
  output reg_data_t       rs2_fwd_o,
`endif
  output reg_addr_t       rd_addr_o,
  output logic            wr_en_o,
  output reg_data_t       wr_data_o,
  output logic [NREG-1:0] busy_o
);

  logic [CNT_W-1:0]           count;
  logic [CNT_W-1:0]           free;
  logic                       mem_push;
  logic                       alu_push;
  logic                       pop;
  wb_entry_t                  head;
  logic [FIFO_DEPTH-1:0]      ord_valid;
  wb_entry_t [FIFO_DEPTH-1:0] ord_ent;

  // free is from the registered count; a same-cycle pop earns no credit
  assign free        = CNT_W'(FIFO_DEPTH) - count;
  assign mem_ready_o = free >= CNT_W'(1);
  assign alu_ready_o = mem_valid_i ? (free >= CNT_W'(2))
                                   : (free >= CNT_W'(1));

  assign mem_push = mem_valid_i & mem_ready_o
                  & (mem_rd_i != '0);
  assign alu_push = alu_valid_i & alu_ready_o
                  & (alu_rd_i != '0);
  assign pop      = count != '0;

  wb_fifo u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push0     (mem_push),
    .din0      ('{rd: mem_rd_i, data: mem_data_i}),
    .push1     (alu_push),
    .din1      ('{rd: alu_rd_i, data: alu_data_i}),
    .pop       (pop),
    .head      (head),
    .count     (count),
    .ord_valid (ord_valid),
    .ord_ent   (ord_ent)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_en_o   <= 1'b0;
      rd_addr_o <= '0;
      wr_data_o <= '0;
    end else begin
      wr_en_o <= pop;
      if (pop) begin
        rd_addr_o <= head.rd;
        wr_data_o <= head.data;
      end
    end
  end

  always_comb begin
    busy_o = '0;
    for (int k = 0; k < FIFO_DEPTH; k++)
      if (ord_valid[k])
        busy_o[ord_ent[k].rd] = 1'b1;
    if (wr_en_o)
      busy_o[rd_addr_o] = 1'b1;
    busy_o[0] = 1'b0;
  end

`ifdef WB_BYPASS_EN
  // oldest-to-youngest scan so the youngest match wins
  function automatic reg_data_t fwd(
    input reg_addr_t                  a,
    input reg_data_t                  rf,
    input logic [FIFO_DEPTH-1:0]      v,
    input wb_entry_t [FIFO_DEPTH-1:0] e,
    input logic                       we,
    input reg_addr_t                  wa,
    input reg_data_t                  wd
  );
    reg_data_t r;
    r = rf;
    if (we && wa == a)
      r = wd;
    for (int k = 0; k < FIFO_DEPTH; k++)
      if (v[k] && e[k].rd == a)
        r = e[k].data;
    if (a == '0)
      r = '0;
    return r;
  endfunction

  assign rs1_fwd_o = fwd(rs1_addr_i, rs1_data_i,
                         ord_valid, ord_ent,
                         wr_en_o, rd_addr_o, wr_data_o);
  assign rs2_fwd_o = fwd(rs2_addr_i, rs2_data_i,
                         ord_valid, ord_ent,
                         wr_en_o, rd_addr_o, wr_data_o);
`endif

endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// Directed bench for regfile_wb_ctrl: vector table plus queue model.
// Bypass checks build only with WB_BYPASS_EN.
module tb_regfile_wb_ctrl;

  logic        clk;
  logic        reset_n;
  logic        mem_valid_i;
  logic        mem_ready_o;
  logic [2:0]  mem_rd_i;
  logic [18:0] mem_data_i;
  logic        alu_valid_i;
  logic        alu_ready_o;
  logic [2:0]  alu_rd_i;
  logic [18:0] alu_data_i;
  logic [2:0]  rd_addr_o;
  logic        wr_en_o;
  logic [18:0] wr_data_o;
  logic [7:0]  busy_o;
`ifdef WB_BYPASS_EN
  logic [2:0]  rs1_addr_i;
  logic [2:0]  rs2_addr_i;
  logic [18:0] rs1_data_i;
  logic [18:0] rs2_data_i;
  logic [18:0] rs1_fwd_o;
  logic [18:0] rs2_fwd_o;
`endif

  regfile_wb_ctrl dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .mem_valid_i (mem_valid_i),
    .mem_ready_o (mem_ready_o),
    .mem_rd_i    (mem_rd_i),
    .mem_data_i  (mem_data_i),
    .alu_valid_i (alu_valid_i),
    .alu_ready_o (alu_ready_o),
    .alu_rd_i    (alu_rd_i),
    .alu_data_i  (alu_data_i),
`ifdef WB_BYPASS_EN
    .rs1_addr_i  (rs1_addr_i),
    .rs2_addr_i  (rs2_addr_i),
    .rs1_data_i  (rs1_data_i),
    .rs2_data_i  (rs2_data_i),
    .rs1_fwd_o   (rs1_fwd_o),
    .rs2_fwd_o   (rs2_fwd_o),
`endif
    .rd_addr_o   (rd_addr_o),
    .wr_en_o     (wr_en_o),
    .wr_data_o   (wr_data_o),
    .busy_o      (busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        mv;
    logic [2:0]  mrd;
    logic [18:0] md;
    logic        av;
    logic [2:0]  ard;
    logic [18:0] ad;
    logic        mr;
    logic        ar;
    logic        we;
    logic [2:0]  rd;
    logic [18:0] wd;
    logic [7:0]  bz;
  } vec_t;

  typedef struct packed {
    logic [2:0]  rd;
    logic [18:0] d;
  } ent_t;

  int   checks;
  int   failures;
  int   writes;
  int   accepted;
  logic stalled_seen;
  ent_t q[$];
  ent_t out_m;
  logic out_v;
  vec_t tv[12];

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h",
               name, act, exp);
    end
  endtask

  task automatic drive(input logic mv,
                       input logic [2:0] mrd,
                       input logic [18:0] md,
                       input logic av,
                       input logic [2:0] ard,
                       input logic [18:0] ad);
    mem_valid_i = mv;
    mem_rd_i    = mrd;
    mem_data_i  = md;
    alu_valid_i = av;
    alu_rd_i    = ard;
    alu_data_i  = ad;
  endtask

  // One cycle against the queue model; checks readies, write port, busy
  task automatic cyc(input logic mv,
                     input logic [2:0] mrd,
                     input logic [18:0] md,
                     input logic av,
                     input logic [2:0] ard,
                     input logic [18:0] ad);
    int         fr;
    logic       emr;
    logic       ear;
    logic [7:0] bz;
    drive(mv, mrd, md, av, ard, ad);
    #1;
    fr  = 4 - q.size();
    emr = fr >= 1;
    ear = mv ? (fr >= 2) : (fr >= 1);
    chk("m_mem_ready", 32'(mem_ready_o), 32'(emr));
    chk("m_alu_ready", 32'(alu_ready_o), 32'(ear));
    if (av && !alu_ready_o)
      stalled_seen = 1'b1;
    @(posedge clk);
    out_v = 1'b0;
    if (q.size() > 0) begin
      out_m = q.pop_front();
      out_v = 1'b1;
    end
    if (mv && emr && mrd != 3'd0) begin
      q.push_back('{mrd, md});
      accepted++;
    end
    if (av && ear && ard != 3'd0) begin
      q.push_back('{ard, ad});
      accepted++;
    end
    #1;
    if (wr_en_o)
      writes++;
    chk("m_wr_en", 32'(wr_en_o), 32'(out_v));
    if (out_v) begin
      chk("m_rd_addr", 32'(rd_addr_o), 32'(out_m.rd));
      chk("m_wr_data", 32'(wr_data_o), 32'(out_m.d));
    end
    bz = '0;
    foreach (q[i])
      bz[q[i].rd] = 1'b1;
    if (out_v)
      bz[out_m.rd] = 1'b1;
    bz[0] = 1'b0;
    chk("m_busy", 32'(busy_o), 32'(bz));
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    drive(1'b0, 3'd0, 19'd0, 1'b0, 3'd0, 19'd0);
    q.delete();
    out_v = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  initial begin
    checks       = 0;
    failures     = 0;
    writes       = 0;
    accepted     = 0;
    stalled_seen = 1'b0;
`ifdef WB_BYPASS_EN
    rs1_addr_i = '0;
    rs2_addr_i = '0;
    rs1_data_i = '0;
    rs2_data_i = '0;
`endif

    tv[0]  = '{1'b0,3'd0,19'h0,     1'b0,3'd0,19'h0,
               1'b1,1'b1,1'b0,3'd0,19'h0,    8'h00};
    tv[1]  = '{1'b0,3'd0,19'h0,     1'b1,3'd3,19'h1ABCD,
               1'b1,1'b1,1'b0,3'd0,19'h0,    8'h08};
    tv[2]  = '{1'b0,3'd0,19'h0,     1'b0,3'd0,19'h0,
               1'b1,1'b1,1'b1,3'd3,19'h1ABCD,8'h08};
    tv[3]  = '{1'b0,3'd0,19'h0,     1'b0,3'd0,19'h0,
               1'b1,1'b1,1'b0,3'd3,19'h1ABCD,8'h00};
    tv[4]  = '{1'b1,3'd2,19'h00011, 1'b1,3'd5,19'h7FFFF,
               1'b1,1'b1,1'b0,3'd3,19'h1ABCD,8'h24};
    tv[5]  = '{1'b0,3'd0,19'h0,     1'b0,3'd0,19'h0,
               1'b1,1'b1,1'b1,3'd2,19'h00011,8'h24};
    tv[6]  = '{1'b0,3'd0,19'h0,     1'b0,3'd0,19'h0,
               1'b1,1'b1,1'b1,3'd5,19'h7FFFF,8'h20};
    tv[7]  = '{1'b0,3'd0,19'h0,     1'b1,3'd0,19'h12345,
               1'b1,1'b1,1'b0,3'd5,19'h7FFFF,8'h00};
    tv[8]  = '{1'b0,3'd0,19'h0,     1'b0,3'd0,19'h0,
               1'b1,1'b1,1'b0,3'd5,19'h7FFFF,8'h00};
    tv[9]  = '{1'b1,3'd0,19'h00001, 1'b1,3'd6,19'h00666,
               1'b1,1'b1,1'b0,3'd5,19'h7FFFF,8'h40};
    tv[10] = '{1'b0,3'd0,19'h0,     1'b0,3'd0,19'h0,
               1'b1,1'b1,1'b1,3'd6,19'h00666,8'h40};
    tv[11] = '{1'b0,3'd0,19'h0,     1'b0,3'd0,19'h0,
               1'b1,1'b1,1'b0,3'd6,19'h00666,8'h00};

    reset_n = 1'b0;
    drive(1'b0, 3'd0, 19'd0, 1'b0, 3'd0, 19'd0);
    #2;
    chk("rst_wr_en",   32'(wr_en_o),   32'd0);
    chk("rst_rd_addr", 32'(rd_addr_o), 32'd0);
    chk("rst_wr_data", 32'(wr_data_o), 32'd0);
    chk("rst_busy",    32'(busy_o),    32'd0);
    do_reset();

    for (int i = 0; i < 12; i++) begin
      drive(tv[i].mv, tv[i].mrd, tv[i].md,
            tv[i].av, tv[i].ard, tv[i].ad);
      #1;
      chk($sformatf("v%0d_mem_ready", i),
          32'(mem_ready_o), 32'(tv[i].mr));
      chk($sformatf("v%0d_alu_ready", i),
          32'(alu_ready_o), 32'(tv[i].ar));
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_wr_en", i),
          32'(wr_en_o), 32'(tv[i].we));
      chk($sformatf("v%0d_rd_addr", i),
          32'(rd_addr_o), 32'(tv[i].rd));
      chk($sformatf("v%0d_wr_data", i),
          32'(wr_data_o), 32'(tv[i].wd));
      chk($sformatf("v%0d_busy", i),
          32'(busy_o), 32'(tv[i].bz));
    end

    // sustained dual input: queue fills, alu throttled, order kept
    do_reset();
    writes   = 0;
    accepted = 0;
    for (int k = 0; k < 6; k++)
      cyc(1'b1, 3'(k + 1), 19'h10000 + 19'(k),
          1'b1, 3'(k + 2), 19'h20000 + 19'(k));
    for (int n = 0; n < 12 && q.size() > 0; n++)
      cyc(1'b0, 3'd0, 19'd0, 1'b0, 3'd0, 19'd0);
    cyc(1'b0, 3'd0, 19'd0, 1'b0, 3'd0, 19'd0);
    chk("t4_alu_throttled", 32'(stalled_seen), 32'd1);
    chk("t4_write_count", 32'(writes), 32'(accepted));

    // reset mid-drain drops queued writes
    do_reset();
    cyc(1'b1, 3'd1, 19'h00101, 1'b1, 3'd2, 19'h00202);
    cyc(1'b0, 3'd0, 19'd0,     1'b1, 3'd3, 19'h00303);
    #2;
    reset_n = 1'b0;
    #1;
    chk("t5_async_wr_en", 32'(wr_en_o),   32'd0);
    chk("t5_async_busy",  32'(busy_o),    32'd0);
    chk("t5_async_rd",    32'(rd_addr_o), 32'd0);
    q.delete();
    out_v = 1'b0;
    drive(1'b0, 3'd0, 19'd0, 1'b0, 3'd0, 19'd0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    writes  = 0;
    repeat (4)
      cyc(1'b0, 3'd0, 19'd0, 1'b0, 3'd0, 19'd0);
    chk("t5_no_writes", 32'(writes), 32'd0);

`ifdef WB_BYPASS_EN
    do_reset();
    cyc(1'b0, 3'd0, 19'd0, 1'b1, 3'd4, 19'h00AAA);
    cyc(1'b0, 3'd0, 19'd0, 1'b1, 3'd4, 19'h00BBB);
    drive(1'b0, 3'd0, 19'd0, 1'b0, 3'd0, 19'd0);
    rs1_addr_i = 3'd4;
    rs1_data_i = 19'h00000;
    rs2_addr_i = 3'd0;
    rs2_data_i = 19'h7FFFF;
    #1;
    chk("t6_rs1_youngest", 32'(rs1_fwd_o), 32'h00BBB);
    chk("t6_rs2_zero",     32'(rs2_fwd_o), 32'h0);
    rs2_addr_i = 3'd6;
    rs2_data_i = 19'h00123;
    #1;
    chk("t6_rs2_regfile",  32'(rs2_fwd_o), 32'h00123);
    cyc(1'b0, 3'd0, 19'd0, 1'b0, 3'd0, 19'd0);
    chk("t6_rs1_outstage", 32'(rs1_fwd_o), 32'h00BBB);
`endif

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
